// File: rtl/adder_pkg.sv
// adder_pkg
//    Shared definitions for the bit-serial adder: FSM state encoding and
//    the default operand width.
package adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_t;

endpackage

// File: rtl/fa_ha.sv
// fa_ha
//    Combinational one-bit full adder built from two half adders.
//    Ports:
//       a, b  in   operand bits
//       ci    in   carry in
//       s     out  sum bit
//       co    out  carry out
module fa_ha (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic ha0_s;
   logic ha0_c;
   logic ha1_c;

   // First half adder: a + b
   assign ha0_s = a ^ b;
   assign ha0_c = a & b;

   // Second half adder: partial sum + carry in
   assign s     = ha0_s ^ ci;
   assign ha1_c = ha0_s & ci;

   assign co    = ha0_c | ha1_c;

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//    Bit-serial adder. Operands are captured on an accepted start, then one
//    bit pair per clock (LSB first) goes through a single fa_ha cell with
//    the carry recirculated through a flop. After WIDTH bits the result is
//    registered into sum/cout and done pulses for one cycle.
//    Ports:
//       clk    in   rising-edge clock
//       rst_n  in   synchronous active-low reset
//       start  in   operation request, ignored while busy
//       a, b   in   WIDTH-bit operands, captured on accepted start
//       cin    in   carry in, captured on accepted start
//       busy   out  high while bits are being processed
//       done   out  one-cycle pulse when sum/cout have just updated
//       sum    out  WIDTH-bit result, held until the next completion
//       cout   out  carry out, held until the next completion
module serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   logic             fa_s;
   logic             fa_co;
   logic [WIDTH-1:0] sum_sr_shift;

   fa_ha u_fa_ha (
      .a  (a_sr_q[0]),
      .b  (b_sr_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   // New sum bit enters at the MSB; written with shifts so that WIDTH=1
   // needs no zero-width slice.
   assign sum_sr_shift = (sum_sr_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      sum_sr_d = sum_sr_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      cout_d   = cout_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               a_sr_d   = a;
               b_sr_d   = b;
               carry_d  = cin;
               cnt_d    = '0;
               sum_sr_d = '0;
               state_d  = S_RUN;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_RUN: begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            sum_sr_d = sum_sr_shift;
            carry_d  = fa_co;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               sum_d   = sum_sr_shift;
               cout_d  = fa_co;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         sum_sr_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         sum_sr_q <= sum_sr_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
      end
   end

   // Status decoded from registered state only.
   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder built around the existing `fa_ha` full-adder cell. The block accepts two WIDTH-bit operands and a carry-in with a start pulse. It feeds one bit pair per clock, LSB first, through a single `fa_ha` instance and recirculates the carry through a flip-flop. It then presents the registered sum and carry-out with a one-cycle done pulse. It sits directly downstream of operand sources and is the sequential consumer of `fa_ha` outputs.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 1..32.
- `clk`  in  1  rising-edge clock, single clock domain
- `rst_n`  in  1  reset; synchronous, active-low
- `start`  in  1  request; sampled only when not busy
- `a`  in  WIDTH  operand A, captured on accepted start
- `b`  in  WIDTH  operand B, captured on accepted start
- `cin`  in  1  carry-in, captured on accepted start
- `busy`  out  1  high while bits are being processed
- `done`  out  1  one-cycle pulse: `sum`/`cout` just updated
- `sum`  out  WIDTH  result register, holds until next completion
- `cout`  out  1  carry-out register, holds until next completion

## Operation
- States are IDLE, RUN and DONE.
- IDLE:
  - `start`=1 at a rising edge loads `a_sr`<=a, `b_sr`<=b, `carry`<=cin, `cnt`<=0 and `sum_sr`<=0, then moves to RUN.
  - `start`=0 keeps the block in IDLE.
- RUN:
  - `fa_ha` inputs are `a_sr[0]`, `b_sr[0]` and `carry`.
  - Each edge: `a_sr` and `b_sr` shift right by 1; `sum_sr` shifts right with the `fa_ha` sum bit entering the MSB; `carry`<=`fa_ha` carry; `cnt`++.
  - On the edge where `cnt`==WIDTH-1: `sum`<= final `sum_sr` value including the current bit, `cout`<= `fa_ha` carry, then move to DONE.
- DONE: `done`=1 for exactly this cycle.
  - `start`=1 is accepted exactly as in IDLE, loading new operands and moving to RUN, so back-to-back operations have no gap cycle.
  - Otherwise the block moves to IDLE.
- `start` while in RUN is ignored, with no queueing. `a`, `b` and `cin` may change freely after acceptance.
- Arithmetic is modulo 2^WIDTH in `sum`; the overflow bit goes to `cout`. `cnt` width is $clog2(WIDTH)+1.
- Reset (`rst_n`=0 at an edge) from any state, including mid-RUN:
  - state goes to IDLE;
  - `busy`, `done`, `sum`, `cout`, `carry`, `cnt` and all shift registers go to 0;
  - the partial result is discarded.
- `busy` = (state==RUN); `done` = (state==DONE). Both are decoded from registered state, with no combinational path from inputs.

## Timing
- Accept edge E0 (start sampled high). RUN occupies the WIDTH cycles after E0.
- `sum`/`cout` update at edge E0+WIDTH. `done` is high for the cycle following that edge.
- Latency from accept to done: WIDTH+1 edges. Throughput: one addition per WIDTH+1 cycles; no idle cycle is required between operations.
- WIDTH=1: a single RUN cycle; the same rules apply.

## Structure
- Shared package/header `adder_pkg` holds:
  - state encoding constants `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_DONE`=2'd2;
  - the default `WIDTH`.
- One sub-module: the existing `fa_ha`, instantiated once, purely combinational in RUN.
- Carry flip-flop, shift registers, counter and FSM are in `serial_adder`.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0 -> `busy` for 8 cycles, then `done` pulse; `sum`=0x96, `cout`=0; accept-to-done = 9 edges.
- a=0xFF, b=0x01, cin=0 -> `sum`=0x00, `cout`=1. a=0xFF, b=0x00, cin=1 -> `sum`=0x00, `cout`=1.
- `start` held high with a=0x10, b=0x20 while in RUN, then new operands applied -> only the first operation completes (`sum`=0x30); the start pulses during RUN are ignored.
- `start` asserted in the DONE cycle with a=0x01, b=0x02 -> RUN entered on the next edge with no gap; second `done` 9 edges later with `sum`=0x03, while the first `sum` stays valid until then.
- `rst_n`=0 at the 4th RUN cycle -> next cycle: all outputs 0, state IDLE; the next operation a=0x7F, b=0x01 gives `sum`=0x80, `cout`=0.
- Exhaustive compare for WIDTH=4, all a, b and cin combinations -> {`cout`,`sum`} == a+b+cin in every case.
